// File: rtl/uart_rx_buffer_if.sv
// Consumer-side bundle for uart_rx_buffer: serial line in, FWFT byte stream out, error pulses.
// The receiver uses the slave modport; the consumer or testbench uses master.
interface uart_rx_buffer_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       overrun;
    logic       framing_err;
    logic       parity_err;

    modport slave (
        input  rx,
        input  ready,
        output data,
        output valid,
        output overrun,
        output framing_err,
        output parity_err
    );

    modport master (
        output rx,
        output ready,
        input  data,
        input  valid,
        input  overrun,
        input  framing_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// 8-bit UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN for an even-parity bit between bit 7 and the stop bit.
module uart_rx_buffer #(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic             clk,
    input logic             clr_n,
    uart_rx_buffer_if.slave bus
);
    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned HalfBit    = ClksPerBit / 2;
    localparam int unsigned TimerW     = $clog2(ClksPerBit);
    localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW       = AddrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    // ---------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle (high) line level.
    // ---------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------------
    state_e              state_q;
    logic [TimerW-1:0]   timer_q;
    logic [2:0]          bit_cnt_q;
    logic [7:0]          shift_q;
    logic                framing_err_q;
    logic                parity_err_q;
    logic                half_done;
    logic                bit_done;
    logic                stop_sample;
    logic                push_req;

    assign half_done   = (timer_q == TimerW'(HalfBit - 1));
    assign bit_done    = (timer_q == TimerW'(ClksPerBit - 1));
    assign stop_sample = (state_q == StStop) && bit_done;

`ifdef UART_RX_PARITY_EN
    logic par_bit_q;
    logic parity_bad;

    assign parity_bad = (par_bit_q != ^shift_q);
    assign push_req   = stop_sample && rx_sync_q && !parity_bad;
`else
    assign push_req   = stop_sample && rx_sync_q;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q     <= 1'b0;
`endif
        end else begin
            framing_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    timer_q   <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (half_done) begin
                        timer_q <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_q <= rx_sync_q ? StIdle : StData;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StData: begin
                    if (bit_done) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= StParity;
`else
                            state_q <= StStop;
`endif
                        end
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (bit_done) begin
                        timer_q   <= '0;
                        par_bit_q <= rx_sync_q;
                        state_q   <= StStop;
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
`endif
                StStop: begin
                    if (bit_done) begin
                        timer_q <= '0;
                        if (!rx_sync_q) begin
                            framing_err_q <= 1'b1;
                            state_q       <= StWaitIdle;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            parity_err_q  <= parity_bad;
`endif
                            state_q       <= StIdle;
                        end
                    end else begin
                        timer_q <= timer_q + TimerW'(1);
                    end
                end
                StWaitIdle: begin
                    if (rx_sync_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FWFT FIFO; pointers carry one extra wrap bit to tell full from empty.
    // ---------------------------------------------------------------------
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] rd_ptr_d;
    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            overrun_q;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign do_pop  = !empty && bus.ready;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push_req && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= push_req && full && !do_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
        end
    end

    assign bus.valid       = !empty;
    assign bus.data        = empty ? 8'h00 : mem_q[rd_ptr_q[AddrW-1:0]];
    assign bus.overrun     = overrun_q;
    assign bus.framing_err = framing_err_q;
    assign bus.parity_err  = parity_err_q;

    a_err_exclusive: assert property (@(posedge clk) disable iff (!clr_n)
        $onehot0({overrun_q, framing_err_q, parity_err_q}));

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer at 16 clocks/bit with a 4-deep FIFO; a queue model of the
// FIFO is checked every cycle, and literal checks pin the model at key points.
`timescale 1ns/1ps
module tb_uart_rx_buffer;
    localparam int CPB   = 16;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // Edges from driving the start bit to the stop sample: 2 sync flops + IDLE detect,
    // half a bit to the start sample, then one bit time per remaining bit.
    localparam int LAT = 3 + HALF + NBITS * CPB;

    typedef struct {
        int         edge_n;
        logic [7:0] b;
        bit         stop_ok;
        bit         par_ok;
    } ev_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    uart_rx_buffer_if bus ();

    uart_rx_buffer #(
        .CLK_FREQ  (1600),
        .BAUD      (100),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    ev_t        ev_q[$];
    logic [7:0] mq[$];
    int         cyc = 0;
    bit         e_ov, e_fe, e_pe;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ov_seen = 0, fe_seen = 0, pe_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Model: apply pops and scheduled stop samples at each rising edge.
    initial begin : model
        ev_t        e;
        bit         pop, push;
        logic [7:0] pb;
        forever begin
            @(posedge clk);
            cyc++;
            e_ov = 0; e_fe = 0; e_pe = 0;
            if (clr_n) begin
                pop  = (mq.size() > 0) && bus.ready;
                push = 0;
                pb   = 8'h00;
                if (ev_q.size() > 0 && ev_q[0].edge_n == cyc) begin
                    e = ev_q.pop_front();
                    if (!e.stop_ok) e_fe = 1;
                    else if (!e.par_ok) e_pe = 1;
                    else if (mq.size() == DEPTH && !pop) e_ov = 1;
                    else begin push = 1; pb = e.b; end
                end
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(pb);
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                mq.delete();
                ev_q.delete();
                e_ov = 0; e_fe = 0; e_pe = 0;
                chk("reset_data", bus.data, 8'h00);
            end
            chk("valid", bus.valid, mq.size() > 0);
            if (mq.size() > 0) chk("data", bus.data, mq[0]);
            chk("overrun", bus.overrun, e_ov);
            chk("framing_err", bus.framing_err, e_fe);
            chk("parity_err", bus.parity_err, e_pe);
            if (bus.overrun) ov_seen++;
            if (bus.framing_err) fe_seen++;
            if (bus.parity_err) pe_seen++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench still running at %0t, want finished", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left #1 after a rising edge, so frames chain back-to-back.
    task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_bit);
        ev_t e;
        e.edge_n  = cyc + LAT;
        e.b       = b;
        e.stop_ok = stop_ok;
`ifdef UART_RX_PARITY_EN
        e.par_ok  = (par_bit == ^b);
`else
        e.par_ok  = 1'b1;
`endif
        ev_q.push_back(e);
        bus.rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            wait_cycles(CPB);
        end
`ifdef UART_RX_PARITY_EN
        bus.rx = par_bit;
        wait_cycles(CPB);
`endif
        if (stop_ok) begin
            bus.rx = 1'b1;
            wait_cycles(CPB);
        end else begin
            bus.rx = 1'b0;
            wait_cycles(2 * CPB);
            bus.rx = 1'b1;
            wait_cycles(CPB);
        end
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b1, ^b);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        chk(name, bus.data, exp);
        bus.ready = 1'b1;
        wait_cycles(1);
        bus.ready = 1'b0;
    endtask

    initial begin : stimulus
        int ov0, fe0, pe0;
        logic [7:0] seq [4];
        bus.rx    = 1'b1;
        bus.ready = 1'b0;
        wait_cycles(2);
        chk("reset_valid", bus.valid, 1'b0);
        clr_n = 1'b1;
        wait_cycles(4);

        // Single byte, then one-cycle pop.
        send_ok(8'h41);
        chk("t1_valid", bus.valid, 1'b1);
        chk("t1_data", bus.data, 8'h41);
        bus.ready = 1'b1;
        wait_cycles(1);
        bus.ready = 1'b0;
        chk("t1_valid_after_pop", bus.valid, 1'b0);
        wait_cycles(5);

        // Four back-to-back bytes, drained in order.
        seq = '{8'h1B, 8'h59, 8'h25, 8'h30};
        for (int i = 0; i < 4; i++) send_ok(seq[i]);
        for (int i = 0; i < 4; i++) pop_expect("t2_order", seq[i]);
        chk("t2_valid_empty", bus.valid, 1'b0);
        wait_cycles(5);

        // Overrun: fifth byte into a full FIFO is dropped.
        ov0 = ov_seen;
        seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) send_ok(seq[i]);
        send_ok(8'hE5);
        chk("t3_overrun_count", ov_seen - ov0, 1);
        for (int i = 0; i < 4; i++) pop_expect("t3_kept", seq[i]);
        chk("t3_valid_empty", bus.valid, 1'b0);
        wait_cycles(5);

        // Same, but the consumer pops on the fifth push edge.
        ov0 = ov_seen;
        for (int i = 0; i < 4; i++) send_ok(seq[i]);
        fork
            send_ok(8'hE5);
            begin
                wait_cycles(LAT - 1);
                bus.ready = 1'b1;
                wait_cycles(1);
                bus.ready = 1'b0;
            end
        join
        chk("t3b_no_overrun", ov_seen - ov0, 0);
        pop_expect("t3b_kept", 8'hB2);
        pop_expect("t3b_kept", 8'hC3);
        pop_expect("t3b_kept", 8'hD4);
        pop_expect("t3b_kept", 8'hE5);
        chk("t3b_valid_empty", bus.valid, 1'b0);
        wait_cycles(5);

        // Framing error, then recovery.
        fe0 = fe_seen;
        send(8'h55, 1'b0, ^8'h55);
        chk("t4_framing_count", fe_seen - fe0, 1);
        chk("t4_valid", bus.valid, 1'b0);
        send_ok(8'h7E);
        chk("t4_recover_valid", bus.valid, 1'b1);
        pop_expect("t4_recover_data", 8'h7E);
        wait_cycles(5);

        // Short low glitch on idle line.
        fe0 = fe_seen;
        bus.rx = 1'b0;
        wait_cycles(6);
        bus.rx = 1'b1;
        wait_cycles(2 * CPB);
        chk("t5_glitch_valid", bus.valid, 1'b0);
        chk("t5_glitch_err", fe_seen - fe0, 0);

        // Reset during bit 3 of 8'hFF, line then left idle.
        bus.rx = 1'b0;
        wait_cycles(CPB);
        bus.rx = 1'b1;
        wait_cycles(3 * CPB + HALF);
        clr_n = 1'b0;
        wait_cycles(3);
        clr_n = 1'b1;
        wait_cycles(8 * CPB);
        chk("t6_valid_after_reset", bus.valid, 1'b0);
        send_ok(8'h0D);
        chk("t6_next_valid", bus.valid, 1'b1);
        pop_expect("t6_next_data", 8'h0D);
        wait_cycles(5);

`ifdef UART_RX_PARITY_EN
        pe0 = pe_seen;
        send(8'h03, 1'b1, 1'b1);
        chk("t7_parity_count", pe_seen - pe0, 1);
        chk("t7_parity_valid", bus.valid, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        chk("t7_good_valid", bus.valid, 1'b1);
        pop_expect("t7_good_data", 8'h03);
        wait_cycles(5);
`else
        pe0 = pe_seen;
        chk("t7_parity_never", pe0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
